// File: rtl/wide_add_sequencer_pkg.sv
// Shared constants for the wide add/subtract sequencer.
// Slice width of the shared adder and the control FSM state encoding.
// No ports; imported by wide_add_sequencer.
package wide_add_sequencer_pkg;

   localparam int SLICE_W  = 32;
   localparam int SLICE_LB = 5;   // log2(SLICE_W), used to form slice base offsets

   // 2'd3 is not a legal state; the FSM recovers from it to ST_IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

endpackage

// File: rtl/CLA32bit.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups, group carries chained.
// Latency: purely combinational. Backpressure: none.
// Ports: a_i, b_i, cin_i operands/carry-in; sum_o, cout_o carry-out, of_o signed overflow.
module CLA32bit (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        cin_i,
   output logic [31:0] sum_o,
   output logic        cout_o,
   output logic        of_o
);

   // Returns {of, cout, sum}. Kept in a function so the carry chain is
   // built from local variables rather than a self-referencing net.
   function automatic logic [33:0] cla_add(input logic [31:0] x,
                                           input logic [31:0] y,
                                           input logic        ci);
      logic [31:0] g;
      logic [31:0] p;
      logic [32:0] c;
      logic        gg;
      logic        pp;
      g    = x & y;
      p    = x ^ y;
      c    = '0;
      c[0] = ci;
      for (int k = 0; k < 8; k++) begin
         c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
         c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & c[4*k]);
         c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                  | (p[4*k+2] & p[4*k+1] & p[4*k] & c[4*k]);
         gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
            | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
         pp = &p[4*k +: 4];
         c[4*k+4] = gg | (pp & c[4*k]);
      end
      // Signed overflow: carry into the MSB differs from carry out of it.
      return {c[32] ^ c[31], c[32], p ^ c[31:0]};
   endfunction

   assign {of_o, cout_o, sum_o} = cla_add(a_i, b_i, cin_i);

endmodule

// File: rtl/wide_add_sequencer.sv
// WORDS x 32-bit add/subtract, streamed LS word first through one CLA32bit.
// Latency: accept in cycle T -> out_valid in cycle T+WORDS+1; one op in flight.
// Backpressure: result held stable in DONE until out_ready; in_ready low until then.
// Ports: clk/rst (sync, active-high); in_valid/in_ready/op_sub/a/b producer side;
//        out_valid/out_ready/sum/cout/of consumer side.
module wide_add_sequencer
   import wide_add_sequencer_pkg::*;
#(
   parameter  int WORDS = 4,
   localparam int W     = SLICE_W * WORDS
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic         op_sub,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] sum,
   output logic         cout,
   output logic         of
);

   localparam int IDXW = $clog2(WORDS);

   state_e                   state_q, state_d;
   logic [IDXW-1:0]          idx_q, idx_d;
   logic                     carry_q, carry_d;
   logic [W-1:0]             a_q, a_d;
   logic [W-1:0]             b_q, b_d;
   logic [W-1:0]             sum_q, sum_d;
   logic                     cout_q, cout_d;
   logic                     of_q, of_d;

   logic [IDXW+SLICE_LB-1:0] base;
   logic [SLICE_W-1:0]       cla_sum;
   logic                     cla_cout;
   logic                     cla_of;

   // Bit offset of the slice currently being processed.
   assign base = {idx_q, {SLICE_LB{1'b0}}};

   CLA32bit u_cla (
      .a_i    (a_q[base +: SLICE_W]),
      .b_i    (b_q[base +: SLICE_W]),
      .cin_i  (carry_q),
      .sum_o  (cla_sum),
      .cout_o (cla_cout),
      .of_o   (cla_of)
   );

   always_comb begin
      state_d   = state_q;
      idx_d     = idx_q;
      carry_d   = carry_q;
      a_d       = a_q;
      b_d       = b_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      of_d      = of_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               // Subtract as a + ~b + 1: the +1 enters as the initial carry.
               a_d     = a;
               b_d     = op_sub ? ~b : b;
               carry_d = op_sub;
               idx_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sum_d[base +: SLICE_W] = cla_sum;
            carry_d                = cla_cout;
            idx_d                  = idx_q + 1'b1;
            if (idx_q == IDXW'(WORDS - 1)) begin
               // Only the top slice's overflow describes the full-width result.
               cout_d  = cla_cout;
               of_d    = cla_of;
               idx_d   = '0;
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
         of_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
         of_q    <= of_d;
      end
   end

   assign sum  = sum_q;
   assign cout = cout_q;
   assign of   = of_q;

endmodule

// File: doc/wide_add_sequencer.md
Name: wide_add_sequencer

Overview:
- Multi-cycle sequencer that performs WORDS×32-bit add/subtract by streaming 32-bit slices through one shared CLA32bit instance, least-significant word first.
- Holds the inter-word carry in a register.
- Sits between an operand producer and a result consumer, both using valid/ready handshakes.
- Provides wide arithmetic (e.g. 128-bit) without replicating the 32-bit adder.

Parameters:
- WORDS, 4, number of 32-bit slices per operation; legal range 2..16.
- W, 32*WORDS, derived total operand width; not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands and op are valid.
- in_ready  output  1  sequencer can accept an operation.
- op_sub  input  1  0 = a+b, 1 = a−b.
- a  input  W  operand A.
- b  input  W  operand B.
- out_valid  output  1  result registers hold a finished result.
- out_ready  input  1  consumer accepts the result.
- sum  output  W  result.
- cout  output  1  carry out of the MSB word; for subtract, 1 = no borrow.
- of  output  1  signed overflow of the full W-bit operation.

Behaviour:
- Clock and reset: one clock, clk. Reset is rst, synchronous and active-high.
- Reset values: state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, of=0, word index=0, carry register=0.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch a, b (b inverted if op_sub) and op_sub. Set carry register to op_sub, index to 0, go to RUN.
  - RUN: in_ready=0. Each cycle, feed slice[index] of latched a/b plus the carry register to CLA32bit. Write its sum into sum[32*index +: 32] and its cout into the carry register. Increment index. When index==WORDS−1, also capture cout and of from this final slice, then go to DONE.
  - DONE: out_valid=1, in_ready=0. On out_ready, go to IDLE with out_valid=0 in the following cycle.
- Latency: accept in cycle T means out_valid=1 in cycle T+WORDS+1. RUN occupies cycles T+1..T+WORDS. No new op is accepted before the result handshake completes. Throughput is one op per WORDS+2 cycles minimum.
- Overflow: taken only from the top slice, i.e. the sign of latched a, the sign of latched (possibly inverted) b, and the result sign. Intermediate-slice overflow is ignored.
- Ordering: sum bits are updated progressively during RUN and must be treated as valid only when out_valid=1. Inputs a, b and op_sub are don't-care outside the accept cycle.
- Backpressure: DONE holds sum, cout and of stable for any number of cycles while out_ready=0.
- in_valid while not in IDLE: ignored. The producer must hold in_valid until the handshake.
- Reset mid-RUN or mid-DONE: the operation is discarded with no out_valid pulse. All registers return to their reset values the cycle after rst is sampled high.
- Exactly one CLA32bit instance; no combinational path from a/b to sum.

Decomposition:
- Shared defines include file holds:
  - slice width constant 32;
  - state encodings IDLE=2'd0, RUN=2'd1, DONE=2'd2. Value 2'd3 is illegal and recovers to IDLE.
- Sub-module: reuse the existing CLA32bit as the single datapath instance. Its of output is used on the final slice only.
- Control (FSM, index counter, carry register) stays in this module.

Test Plan (WORDS=4):
- a=all-ones, b=1, op_sub=0 -> sum=0, cout=1, of=0; out_valid exactly 5 cycles after accept.
- a=0x..._0000_0000_FFFF_FFFF, b=1, add -> sum=0x..._0000_0001_0000_0000, cout=0; checks word-boundary carry.
- a=5, b=7, op_sub=1 -> sum=all-ones except LSB nibble E (−2), cout=0 (borrow), of=0. a=7, b=5, sub -> sum=2, cout=1.
- a=0x7FFF…FFFF, b=1, add -> sum=0x8000…0000, of=1, cout=0. a=0x8000…0000, b=1, sub -> sum=0x7FFF…FFFF, of=1.
- Hold out_ready=0 for 3 cycles in DONE, with in_valid=1 and new operands -> sum/cout/of stable, in_ready=0. Assert out_ready -> IDLE next cycle, then new op accepted and computed correctly.
- Assert rst for 1 cycle at RUN index 2 -> out_valid never pulses; next cycle in_ready=1, sum=0. A following op completes normally.
